// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: request legality, store replication/byte enables,
// and load lane extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_addr_lo,
  input  logic [31:0] req_wdata,
  output logic        req_legal,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    req_legal = 1'b0;
    case (req_funct3)
      F3_B:    req_legal = 1'b1;
      F3_H:    req_legal = ~req_addr_lo[0];
      F3_W:    req_legal = (req_addr_lo == 2'b00);
      F3_BU:   req_legal = ~req_store;
      F3_HU:   req_legal = ~req_store & ~req_addr_lo[0];
      default: req_legal = 1'b0;
    endcase
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << req_addr_lo;
        st_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = req_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = req_wdata;
      end
    endcase
  end

  always_comb begin
    ld_byte = ld_raw[7:0];
    case (ld_addr_lo)
      2'b00:   ld_byte = ld_raw[7:0];
      2'b01:   ld_byte = ld_raw[15:8];
      2'b10:   ld_byte = ld_raw[23:16];
      default: ld_byte = ld_raw[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? ld_raw[31:16] : ld_raw[15:0];
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: stalls the pipeline while a variable-latency
// memory access is outstanding, flags illegal accesses and times out the bus.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              lsu_stall,
  output logic              lsu_done,
  output logic              misalign,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  lsu_state_e        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [2:0]        funct3_reg;
  logic [1:0]        addr_lo_reg;
  logic              we_reg;
  logic              err_reg;
  logic [31:0]       rdata_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [31:0]       mem_wdata_reg;
  logic [3:0]        mem_be_reg;

  logic        req;
  logic        legal;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic        accept;
  logic        ack_take;
  logic        timeout;

  assign req = rd_en | wr_en;

  lsu_align u_align (
    .req_store   (wr_en),
    .req_funct3  (funct3),
    .req_addr_lo (addr[1:0]),
    .req_wdata   (wdata),
    .req_legal   (legal),
    .st_be       (st_be),
    .st_wdata    (st_wdata),
    .ld_funct3   (funct3_reg),
    .ld_addr_lo  (addr_lo_reg),
    .ld_raw      (mem_rdata),
    .ld_data     (ld_data)
  );

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    ack_take   = 1'b0;
    timeout    = 1'b0;
    misalign   = 1'b0;
    lsu_stall  = 1'b0;
    lsu_done   = 1'b0;
    bus_err    = 1'b0;
    mem_req    = 1'b0;
    case (state_reg)
      IDLE: begin
        // Gate on reset so a request held during reset is not acknowledged.
        if (req && reset) begin
          if (legal) begin
            accept     = 1'b1;
            lsu_stall  = 1'b1;
            state_next = ACCESS;
          end else begin
            misalign = 1'b1;
          end
        end
      end
      ACCESS: begin
        mem_req   = 1'b1;
        lsu_stall = 1'b1;
        if (mem_ack) begin
          ack_take   = 1'b1;
          state_next = DONE;
        end else if (cnt_reg == CNT_W'(MAX_WAIT - 1)) begin
          timeout    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        lsu_done   = 1'b1;
        bus_err    = err_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      funct3_reg    <= 3'b000;
      addr_lo_reg   <= 2'b00;
      we_reg        <= 1'b0;
      err_reg       <= 1'b0;
      rdata_reg     <= 32'd0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= 32'd0;
      mem_be_reg    <= 4'b0000;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        funct3_reg    <= funct3;
        addr_lo_reg   <= addr[1:0];
        we_reg        <= wr_en;
        err_reg       <= 1'b0;
        cnt_reg       <= '0;
        mem_addr_reg  <= {addr[ADDR_W-1:2], 2'b00};
        mem_wdata_reg <= st_wdata;
        mem_be_reg    <= wr_en ? st_be : 4'b1111;
      end
      if (state_reg == ACCESS && !mem_ack && !timeout) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (ack_take && !we_reg) begin
        rdata_reg <= ld_data;
      end
      if (timeout) begin
        err_reg <= 1'b1;
        if (!we_reg) begin
          rdata_reg <= 32'd0;
        end
      end
    end
  end

  assign rdata     = rdata_reg;
  assign mem_we    = (state_reg == ACCESS) && we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_be    = mem_be_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: scoreboard of expected completions,
// immediate assertions at every comparison point.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int MAX_WAIT = 4;
  localparam int ADDR_W   = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              rd_en, wr_en;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              lsu_stall, lsu_done, misalign, bus_err;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          stall_n;
    int          req_n;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] last_rdata = 32'd0;

  always #5 clk = ~clk;

  load_store_unit #(.MAX_WAIT(MAX_WAIT), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .lsu_stall (lsu_stall),
    .lsu_done  (lsu_done),
    .misalign  (misalign),
    .bus_err   (bus_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a posedge; returns just after a posedge with the unit idle.
  task automatic run_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int ack_wait,
                        input logic [31:0] mrd, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    exp_t e;
    int stall_n = 0;
    int req_n = 0;
    bit done_seen = 0;
    e.tag     = tag;
    e.rdata   = exp_rdata;
    e.err     = (ack_wait < 0);
    e.stall_n = (ack_wait < 0) ? MAX_WAIT + 1 : ack_wait + 2;
    e.req_n   = (ack_wait < 0) ? MAX_WAIT : ack_wait + 1;
    sb.push_back(e);
    rd_en = rd; wr_en = wr; funct3 = f3; addr = a; wdata = wd;
    mem_rdata = mrd; mem_ack = 1'b0;
    for (int n = 0; n < 40 && !done_seen; n++) begin
      @(negedge clk);
      if (lsu_done) begin
        done_seen = 1;
      end else begin
        if (lsu_stall) stall_n++;
        if (mem_req) begin
          req_n++;
          if (req_n == 1) begin
            check({tag, "_we"}, {31'd0, mem_we}, {31'd0, wr});
            check({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
            check({tag, "_be"}, {28'd0, mem_be}, {28'd0, exp_be});
            if (wr) check({tag, "_wdata"}, mem_wdata, exp_wdata);
          end
        end
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
        mem_ack = (ack_wait >= 0 && req_n == ack_wait);
      end
    end
    check({tag, "_done_seen"}, {31'd0, done_seen}, 32'd1);
    if (sb.size() > 0) e = sb.pop_front();
    check({tag, "_bus_err"}, {31'd0, bus_err}, {31'd0, e.err});
    check({tag, "_stall_at_done"}, {31'd0, lsu_stall}, 32'd0);
    check({tag, "_rdata"}, rdata, e.rdata);
    check({tag, "_stall_cycles"}, stall_n, e.stall_n);
    check({tag, "_req_cycles"}, req_n, e.req_n);
    $display("txn %s: rdata=%h bus_err=%0b stall_cycles=%0d req_cycles=%0d",
             tag, rdata, bus_err, stall_n, req_n);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, lsu_done}, 32'd0);
    @(posedge clk); #1;
    last_rdata = e.rdata;
  endtask

  task automatic run_bad(input string tag, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] a);
    rd_en = rd; wr_en = wr; funct3 = f3; addr = a; wdata = 32'h5555AAAA;
    @(negedge clk);
    check({tag, "_misalign"}, {31'd0, misalign}, 32'd1);
    check({tag, "_stall"}, {31'd0, lsu_stall}, 32'd0);
    check({tag, "_req"}, {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    check({tag, "_misalign_pulse"}, {31'd0, misalign}, 32'd0);
    check({tag, "_req_after"}, {31'd0, mem_req}, 32'd0);
    check({tag, "_rdata_kept"}, rdata, last_rdata);
    $display("txn %s: misalign flagged, rdata=%h", tag, rdata);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; rd_en = 1'b0; wr_en = 1'b0; funct3 = 3'b000;
    addr = '0; wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_rdata", rdata, 32'd0);
    check("rst_flags", {26'd0, lsu_stall, lsu_done, misalign, bus_err, mem_req, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_be", {28'd0, mem_be}, 32'd0);
    $display("txn reset: outputs cleared");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    run_op("sw",  1'b0, 1'b1, F3_W,  32'h100, 32'hDEADBEEF, 0, 32'h0, 4'b1111, 32'hDEADBEEF, 32'h0);
    run_op("lb",  1'b1, 1'b0, F3_B,  32'h103, 32'h0, 0, 32'h80FF1234, 4'b1111, 32'h0, 32'hFFFFFF80);
    run_op("lbu", 1'b1, 1'b0, F3_BU, 32'h103, 32'h0, 0, 32'h80FF1234, 4'b1111, 32'h0, 32'h00000080);
    run_op("lhu", 1'b1, 1'b0, F3_HU, 32'h102, 32'h0, 0, 32'h80FF1234, 4'b1111, 32'h0, 32'h000080FF);
    run_op("sh",  1'b0, 1'b1, F3_H,  32'h102, 32'h1234ABCD, 0, 32'h0, 4'b1100, 32'hABCDABCD, 32'h000080FF);
    run_op("lw_wait2", 1'b1, 1'b0, F3_W, 32'h200, 32'h0, 2, 32'hCAFEF00D, 4'b1111, 32'h0, 32'hCAFEF00D);
    run_op("lh",  1'b1, 1'b0, F3_H,  32'h106, 32'h0, 1, 32'h80011234, 4'b1111, 32'h0, 32'hFFFF8001);
    run_op("sb",  1'b0, 1'b1, F3_B,  32'h101, 32'h000000A5, 0, 32'h0, 4'b0010, 32'hA5A5A5A5, 32'hFFFF8001);

    run_bad("lw_mis",  1'b1, 1'b0, F3_W,   32'h101);
    run_bad("st_f011", 1'b0, 1'b1, 3'b011, 32'h100);
    run_bad("lh_mis",  1'b1, 1'b0, F3_H,   32'h101);
    run_bad("ld_f011", 1'b1, 1'b0, 3'b011, 32'h100);
    run_bad("sbu_ill", 1'b0, 1'b1, F3_BU,  32'h100);

    run_op("lw_timeout", 1'b1, 1'b0, F3_W, 32'h300, 32'h0, -1, 32'h12345678, 4'b1111, 32'h0, 32'h0);
    mem_ack = 1'b1;
    @(negedge clk);
    check("late_ack_done", {31'd0, lsu_done}, 32'd0);
    check("late_ack_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_done2", {31'd0, lsu_done}, 32'd0);
    $display("txn late_ack: ignored");
    @(posedge clk); #1;

    run_op("lw_pre_rst", 1'b1, 1'b0, F3_W, 32'h400, 32'h0, 0, 32'h0BADF00D, 4'b1111, 32'h0, 32'h0BADF00D);
    rd_en = 1'b1; funct3 = F3_W; addr = 32'h404; mem_ack = 1'b0;
    @(posedge clk); #1;
    rd_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_req_before", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_req", {31'd0, mem_req}, 32'd0);
    check("rst_mid_stall", {31'd0, lsu_stall}, 32'd0);
    check("rst_mid_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("rst_mid_ack_done", {31'd0, lsu_done}, 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check("rst_mid_ack_done2", {31'd0, lsu_done}, 32'd0);
    check("rst_mid_rdata2", rdata, 32'd0);
    $display("txn reset_mid_access: access abandoned");
    @(posedge clk); #1;
    last_rdata = 32'd0;

    run_op("rd_wr_both", 1'b1, 1'b1, F3_W, 32'h500, 32'h11223344, 0, 32'hFFFFFFFF, 4'b1111, 32'h11223344, 32'h0);

    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
